// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// Multiplies use one shift-add step per cycle. Divides use one restoring step per cycle.
// Signed operations run on magnitudes, and the sign fix-up happens in FIX.
// HI/LO then commit together.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mult_op,
  input  logic             mt_hi,
  input  logic             write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  typedef enum logic [2:0] {
    OP_NOP = 3'b000, OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
    OP_DIVU = 3'b100, OP_MT = 3'b101, OP_MFLO = 3'b110, OP_MFHI = 3'b111
  } op_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
  logic [WIDTH-1:0]     opnd_q, opnd_d;    // |multiplicand| or |divisor|
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d; // negate product / quotient
  logic                 neg_hi_q, neg_hi_d; // negate remainder
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 accept, is_signed;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;

  assign accept    = write && (state_q == IDLE);
  assign is_signed = (mult_op == OP_MULT) || (mult_op == OP_DIV);
  assign a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;

  // One multiply step and one divide step, computed from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_lo_q ? -acc_q : acc_q;
  end

  // Next-state, datapath update and HI/LO commit.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: if (accept) begin
        unique case (mult_op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            state_d  = CALC;
            cnt_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, a_abs};
            opnd_d   = b_abs;
            is_div_d = (mult_op == OP_DIV) || (mult_op == OP_DIVU);
            neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_d = is_signed && a[WIDTH-1];
            div0_d   = (b == '0);
          end
          OP_MT: begin
            if (mt_hi) hi_d = a;
            else       lo_d = a;
          end
          default: ;
        endcase
      end
      CALC: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          // A zero divisor yields all-ones quotient and the dividend as remainder.
          lo_d = div0_q ? {WIDTH{1'b1}}
                        : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv.
// Stimulus pushes the expected {hi,lo} for each operation.
// A forked monitor pops and compares on every done pulse.
module tb_mips_cpu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic [2:0]   mult_op;
  logic         mt_hi, write;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  typedef struct packed { logic [W-1:0] hi; logic [W-1:0] lo; } exp_t;
  exp_t sb[$];

  int tests_run = 0;
  int tests_failed = 0;

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .mult_op(mult_op),
    .mt_hi(mt_hi), .write(write), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one command for exactly one accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic mh);
    @(negedge clk);
    mult_op = op; a = av; b = bv; mt_hi = mh; write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0; mult_op = 3'b000;
  endtask

  // Count busy cycles after accept and confirm hi/lo hold until commit.
  task automatic wait_idle(output int cycles, output bit stable);
    logic [2*W-1:0] held;
    held   = {hi, lo};
    cycles = 0;
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
      cycles++;
      if ({hi, lo} !== held) stable = 1'b0;
    end
    check("busy_timeout", {63'd0, busy}, 64'd0);
  endtask

  int cyc;
  bit stab;
  int done_cnt;

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (done) begin
          if (sb.size() == 0) check("unexpected_done", {63'd0, done}, 64'd0);
          else begin
            e = sb.pop_front();
            check("result_hi_lo", {hi, lo}, {e.hi, e.lo});
          end
        end
      end
    join_none

    // Reset held with random activity on the inputs.
    reset = 1'b0; write = 1'b1; mult_op = 3'($urandom); a = $urandom; b = $urandom; mt_hi = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hi_lo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    write = 1'b0; mult_op = 3'b000;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_hold", {hi, lo}, 64'd0);
    check("idle_busy_done", {62'd0, busy, done}, 64'd0);

    // MULTU max x max: latency and hold behaviour.
    sb.push_back('{32'hFFFFFFFE, 32'h00000001});
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_idle(cyc, stab);
    check("multu_busy_cycles", 64'(cyc), 64'd33);
    check("multu_hold", {63'd0, stab}, 64'd1);
    @(negedge clk);
    check("done_single_pulse", {63'd0, done}, 64'd0);

    // Signed multiply and divide vectors.
    sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFEB});
    issue(3'b001, 32'hFFFFFFFD, 32'd7, 1'b0);
    wait_idle(cyc, stab);
    check("mult_busy_cycles", 64'(cyc), 64'd33);

    sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(3'b011, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(cyc, stab);

    sb.push_back('{32'h00000000, 32'h80000000});
    issue(3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(cyc, stab);

    // Divide by zero, then a plain unsigned divide.
    sb.push_back('{32'h00001234, 32'hFFFFFFFF});
    issue(3'b100, 32'h1234, 32'd0, 1'b0);
    wait_idle(cyc, stab);
    check("div0_busy_cycles", 64'(cyc), 64'd33);

    sb.push_back('{32'd2, 32'd14});
    issue(3'b100, 32'd100, 32'd7, 1'b0);
    wait_idle(cyc, stab);

    // Move-to HI commits in one edge without busy.
    issue(3'b101, 32'hDEADBEEF, 32'd0, 1'b1);
    check("mthi_value", {hi, 32'd0}, {32'hDEADBEEF, 32'd0});
    check("mthi_no_busy", {63'd0, busy}, 64'd0);

    // Commands issued while busy are ignored.
    sb.push_back('{32'd0, 32'd15});
    issue(3'b010, 32'd3, 32'd5, 1'b0);
    issue(3'b101, 32'h55, 32'd0, 1'b0);
    issue(3'b100, 32'd100, 32'd7, 1'b0);
    wait_idle(cyc, stab);
    check("lockout_hold", {63'd0, stab}, 64'd1);
    repeat (3) @(negedge clk);
    check("lockout_final", {hi, lo}, {32'd0, 32'd15});
    check("lockout_no_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of a divide.
    issue(3'b100, 32'hFFFF, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midreset_hi_lo", {hi, lo}, 64'd0);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midreset_no_done", 64'(done_cnt), 64'd0);

    @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv.md
Name: mips_cpu_muldiv

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair.
- The ALU issues commands on mult_op/write, and the register file issues MTHI/MTLO writes. This block produces the hi/lo values that the ALU's MFHI/MFLO path forwards onto result.
- It computes MULT/MULTU with one shift-add step per cycle and DIV/DIVU with one restoring-division step per cycle, then commits HI/LO atomically.
- It exposes busy so the control unit can stall MFHI/MFLO and any new HI/LO command.

Parameters:
- WIDTH, 32, operand width. HI/LO are each WIDTH bits. Iteration count = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting (0) clears all state immediately.
- a  input  WIDTH  rs operand; dividend for DIV/DIVU; source for MTHI/MTLO.
- b  input  WIDTH  rt operand; divisor for DIV/DIVU.
- mult_op  input  3  command:
  - 000 NOP
  - 001 MULT
  - 010 MULTU
  - 011 DIV
  - 100 DIVU
  - 101 MT (move-to)
  - 110 MFLO (no action here)
  - 111 MFHI (no action here)
- mt_hi  input  1  for MT: 1 writes HI, 0 writes LO.
- write  input  1  command strobe. A command is accepted only when write=1 and busy=0.
- hi  output  WIDTH  registered HI.
- lo  output  WIDTH  registered LO.
- busy  output  1  high while a multiply/divide is in flight.
- done  output  1  one-cycle pulse in the cycle after HI/LO commit.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; any in-flight operation is discarded with no partial commit.
- FSM states: IDLE, CALC, FIX.
  - IDLE + accepted op 001–100: latch operands into internal registers → CALC. For signed ops, latch absolute values and record result signs. Iteration counter = 0.
  - CALC: one iteration per cycle. After the WIDTH-th iteration edge → FIX.
  - FIX: apply sign correction, write hi/lo on the FIX edge, → IDLE, done=1 for the following cycle.
- Latency:
  - Command accepted at edge E0.
  - busy=1 from after E0 through the FIX cycle, i.e. WIDTH+1 cycles (33).
  - hi/lo take the new values at edge E0+WIDTH+1 (E0+33).
  - busy=0 and done=1 in the same cycle as the new values.
  - A new command may be accepted in the done cycle.
- hi/lo never change during CALC; they hold their old values until the FIX commit.
- MT (101) in IDLE: commits in one edge. mt_hi=1 → hi<=a; mt_hi=0 → lo<=a. Does not assert busy or done.
- Ignored commands:
  - Any command with write=1 while busy=1, including MT: no state change. Stalling is the control unit's job.
  - 000, 110 and 111: never change state.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product, signed or unsigned respectively.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
  - Divide by zero, signed or unsigned: lo=0xFFFFFFFF, hi=a (the dividend). Same latency as a normal divide.
- Operand capture: a and b are sampled only at the accept edge. Later changes to a/b are ignored.
- Reset asserted mid-operation: immediate return to IDLE, hi=lo=0, no done pulse.

Test Plan:
- Reset: hold reset=0 with random inputs → hi=lo=0, busy=0, done=0. Release reset, wait 5 idle cycles → outputs unchanged.
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
  - hi/lo unchanged and busy=1 for exactly 33 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- Signed multiply/divide:
  - MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero and overflow:
  - DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234 after 33 cycles.
  - DIVU 100/7 → lo=14, hi=2.
- Move-to and busy lockout:
  - MT mt_hi=1 a=0xDEADBEEF → hi=0xDEADBEEF next edge, busy stays 0.
  - Start MULTU 3×5, then during busy issue MT mt_hi=0 a=0x55 and DIVU.
  - Required result: both ignored; final hi=0, lo=15.
- Reset mid-operation: start DIVU, assert reset at cycle 10 of CALC → hi=lo=0, busy=0 immediately; no done pulse after release.
